// File: rtl/ram_bist_pkg.sv
// rtl/ram_bist_pkg.sv - shared constants and state encoding for the RAM BIST controller
//
// Holds the geometry of the 8x4 registered-read RAM, the default background
// pattern and the controller state enum. Imported by ram_bist_cmp and
// ram_bist_ctrl.

package ram_bist_pkg;

  localparam int BIST_ADDR_W = 4;
  localparam int BIST_DATA_W = 4;
  localparam int BIST_DEPTH  = 8;

  localparam logic [BIST_DATA_W-1:0] BIST_PATTERN = 4'b1010;

  typedef enum logic [2:0] {
    IDLE,
    W0,
    R0,
    R0_DRAIN,
    W1,
    R1,
    R1_DRAIN,
    DONE
  } bist_state_e;

endpackage

// File: rtl/ram_bist_cmp.sv
// rtl/ram_bist_cmp.sv - one-cycle read-compare stage for the RAM BIST controller
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   issue       a read is being presented to the RAM this cycle
//   addr        address of that read
//   exp         data the read is expected to return
//   rdata       RAM registered read data (belongs to the previous cycle's read)
//   mismatch    the read issued last cycle returned something other than exp
//   fail_addr   address of the read being compared this cycle
//   fail_data   data being compared this cycle
//
// The RAM answers one cycle after it samples the address, so the address and
// expected value are carried in a register for exactly that cycle.

module ram_bist_cmp
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = BIST_ADDR_W,
  parameter int DATA_W = BIST_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] exp,
  input  logic [DATA_W-1:0] rdata,
  output logic              mismatch,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] cmp_exp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_valid <= 1'b0;
      cmp_addr  <= '0;
      cmp_exp   <= '0;
    end else begin
      cmp_valid <= issue;
      if (issue) begin
        cmp_addr <= addr;
        cmp_exp  <= exp;
      end
    end
  end

  assign mismatch  = cmp_valid && (rdata != cmp_exp);
  assign fail_addr = cmp_addr;
  assign fail_data = rdata;

endmodule

// File: rtl/ram_bist_ctrl.sv
// rtl/ram_bist_ctrl.sv - March-style BIST initiator for the single-port registered-read RAM
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        single-cycle request, only honoured in IDLE
//   mem_we       RAM write enable (high only in the two write phases)
//   mem_addr     RAM address
//   mem_wdata    RAM write data
//   mem_rdata    RAM read data, valid the cycle after the address is sampled
//   busy         test in progress
//   done         one-cycle completion pulse
//   pass         result, held until the next accepted start
//   fail_addr    address of the first mismatch
//   fail_data    data read at fail_addr
//
// Sequence: write PATTERN ascending, read/check ascending, write ~PATTERN
// descending, read/check descending. Each read phase is followed by a drain
// cycle so the last read's compare lands before the next phase starts.

module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int                ADDR_W  = BIST_ADDR_W,
  parameter int                DATA_W  = BIST_DATA_W,
  parameter int                DEPTH   = BIST_DEPTH,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(BIST_PATTERN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = '0;

  bist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pass_d;
  logic [ADDR_W-1:0] fail_addr_d;
  logic [DATA_W-1:0] fail_data_d;

  logic              issue;
  logic [DATA_W-1:0] exp_sel;
  logic              mismatch;
  logic [ADDR_W-1:0] cmp_fail_addr;
  logic [DATA_W-1:0] cmp_fail_data;

  ram_bist_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (issue),
    .addr      (addr_q),
    .exp       (exp_sel),
    .rdata     (mem_rdata),
    .mismatch  (mismatch),
    .fail_addr (cmp_fail_addr),
    .fail_data (cmp_fail_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pass      <= pass_d;
      fail_addr <= fail_addr_d;
      fail_data <= fail_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pass_d      = pass;
    fail_addr_d = fail_addr;
    fail_data_d = fail_data;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    issue       = 1'b0;
    exp_sel     = PATTERN;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = W0;
          addr_d      = FIRST_ADDR;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
        end
      end

      W0: begin
        mem_we    = 1'b1;
        mem_wdata = PATTERN;
        if (addr_q == LAST_ADDR) begin
          state_d = R0;
          addr_d  = FIRST_ADDR;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end

      R0: begin
        issue   = 1'b1;
        exp_sel = PATTERN;
        if (addr_q == LAST_ADDR) begin
          state_d = R0_DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end

      R0_DRAIN: begin
        state_d = W1;
        addr_d  = LAST_ADDR;
      end

      W1: begin
        mem_we    = 1'b1;
        mem_wdata = ~PATTERN;
        if (addr_q == FIRST_ADDR) begin
          state_d = R1;
          addr_d  = LAST_ADDR;
        end else begin
          addr_d = addr_q - 1'b1;
        end
      end

      R1: begin
        issue   = 1'b1;
        exp_sel = ~PATTERN;
        if (addr_q == FIRST_ADDR) begin
          state_d = R1_DRAIN;
        end else begin
          addr_d = addr_q - 1'b1;
        end
      end

      R1_DRAIN: begin
        state_d = DONE;
        pass_d  = 1'b1;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A mismatch can only surface in a read or drain cycle. It overrides the
    // phase's own progress: the read presented this cycle is never compared,
    // the address freezes, and the controller finishes with pass low. Because
    // the next state is DONE, no later mismatch can overwrite the record.
    if (mismatch) begin
      issue       = 1'b0;
      state_d     = DONE;
      addr_d      = addr_q;
      pass_d      = 1'b0;
      fail_addr_d = cmp_fail_addr;
      fail_data_d = cmp_fail_data;
    end
  end

  assign mem_addr = addr_q;
  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb/tb_ram_bist_ctrl.sv - scoreboard testbench for ram_bist_ctrl with a fault-injecting RAM model

module tb_ram_bist_ctrl;

  typedef struct {
    logic [3:0] addr;
    logic [3:0] data;
  } wr_t;

  typedef struct {
    logic       pass;
    logic [3:0] faddr;
    logic [3:0] fdata;
    int         busy_cycles;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_addr;
  logic [3:0] fail_data;

  int total = 0;
  int bad   = 0;

  wr_t  exp_wr[$];
  res_t exp_res[$];
  int   busy_cnt  = 0;
  int   done_seen = 0;

  // RAM model: 16 words, registered read, single stuck bit0 fault
  logic [3:0] ram [16];
  logic       fault_en   = 1'b0;
  logic [3:0] fault_addr = 4'd0;
  logic       fault_sa1  = 1'b0;

  ram_bist_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    logic [3:0] v;
    v = ram[mem_addr];
    if (fault_en && mem_addr == fault_addr) v[0] = fault_sa1;
    mem_rdata <= v;
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected writes and results as the DUT presents them
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", {24'd0, mem_addr, mem_wdata}, 32'hffff_ffff);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("write", {24'd0, mem_addr, mem_wdata}, {24'd0, e.addr, e.data});
        end
      end
      if (done) begin
        if (exp_res.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          res_t r;
          r = exp_res.pop_front();
          chk("pass", {31'd0, pass}, {31'd0, r.pass});
          chk("fail_addr", {28'd0, fail_addr}, {28'd0, r.faddr});
          chk("fail_data", {28'd0, fail_data}, {28'd0, r.fdata});
          chk("busy_cycles", busy_cnt, r.busy_cycles);
          chk("busy_in_done", {31'd0, busy}, 32'd0);
        end
        busy_cnt = 0;
        done_seen++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_fault(input logic en, input logic [3:0] a, input logic sa1);
    fault_en   = en;
    fault_addr = a;
    fault_sa1  = sa1;
  endtask

  task automatic launch(input logic p, input logic [3:0] fa, input logic [3:0] fd,
                        input int bc, input logic w1);
    for (int i = 0; i < 8; i++) exp_wr.push_back('{addr: 4'(i), data: 4'b1010});
    if (w1) for (int i = 7; i >= 0; i--) exp_wr.push_back('{addr: 4'(i), data: 4'b0101});
    exp_res.push_back('{pass: p, faddr: fa, fdata: fd, busy_cycles: bc});
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n0;
    int k;
    n0 = done_seen;
    k  = 0;
    while (done_seen == n0 && k < 200) begin
      tick();
      k++;
    end
    chk({name, "_done_timeout"}, {31'd0, done_seen == n0}, 32'd0);
    chk({name, "_writes_left"}, exp_wr.size(), 0);
    chk({name, "_results_left"}, exp_res.size(), 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("reset_outputs", {8'd0, mem_we, mem_addr, mem_wdata, busy, done, pass, fail_addr, fail_data}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // fault-free run
    launch(1'b1, 4'd0, 4'd0, 34, 1'b1);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_done("clean");

    // bit0 stuck-at-1 at addr 5: fails in R0
    set_fault(1'b1, 4'd5, 1'b1);
    launch(1'b0, 4'd5, 4'b1011, 15, 1'b0);
    wait_done("r0_a5");

    // rerun clean, with extra starts while busy and in DONE
    set_fault(1'b0, 4'd0, 1'b0);
    launch(1'b1, 4'd0, 4'd0, 34, 1'b1);
    chk("cleared_on_start", {23'd0, pass, fail_addr, fail_data}, 32'd0);
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!done && k < 200) begin
      tick();
      k++;
    end
    chk("done_level_timeout", {31'd0, done}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("ignored_start_busy", {31'd0, busy}, 32'd0);
    chk("ignored_start_results_left", exp_res.size(), 0);
    chk("pass_held", {23'd0, pass, fail_addr, fail_data}, {23'd0, 1'b1, 8'd0});

    // fresh run afterward
    launch(1'b1, 4'd0, 4'd0, 34, 1'b1);
    wait_done("fresh");

    // bit0 stuck-at-0 at addr 2: only ~PATTERN fails
    set_fault(1'b1, 4'd2, 1'b0);
    launch(1'b0, 4'd2, 4'b0100, 32, 1'b1);
    wait_done("r1_a2");

    // last address of R0, caught in drain
    set_fault(1'b1, 4'd7, 1'b1);
    launch(1'b0, 4'd7, 4'b1011, 17, 1'b0);
    wait_done("r0_a7");

    // last address of R1, caught in drain
    set_fault(1'b1, 4'd0, 1'b0);
    launch(1'b0, 4'd0, 4'b0100, 34, 1'b1);
    wait_done("r1_a0");

    // reset during W1 at addr 4
    set_fault(1'b0, 4'd0, 1'b0);
    launch(1'b1, 4'd0, 4'd0, 34, 1'b1);
    k = 0;
    while (!(mem_we && mem_wdata == 4'b0101 && mem_addr == 4'd4) && k < 200) begin
      tick();
      k++;
    end
    chk("w1_a4_timeout", {31'd0, k >= 200}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {8'd0, mem_we, mem_addr, mem_wdata, busy, done, pass, fail_addr, fail_data}, 32'd0);
    exp_wr.delete();
    exp_res.delete();
    tick();
    rst_n = 1'b1;
    tick();
    launch(1'b1, 4'd0, 4'd0, 34, 1'b1);
    wait_done("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
Initiator-side controller for the team's single-port synchronous RAM (8x4, registered read, write-when-we). On a start pulse it runs a 4-phase March-style test: write a pattern, read and check it, write the inverse, read and check it. It reports pass/fail with the first failing address and data. It sits between the system control logic and the ram instance, and owns the RAM's clk-domain port while busy.

Parameters:
ADDR_W, 4, width of mem_addr (matches RAM address port)
DATA_W, 4, width of RAM data
DEPTH, 8, number of locations tested (addresses 0..DEPTH-1; DEPTH <= 2**ADDR_W)
PATTERN, 4'b1010, background data for phase 1; phase 3 uses ~PATTERN

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request; sampled only in IDLE
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM registered read data (valid the cycle after the read address is sampled)
busy  out  1  high from the first cycle after start is accepted until done
done  out  1  one-cycle completion pulse
pass  out  1  result, valid from done until the next accepted start
fail_addr  out  ADDR_W  address of the first mismatch
fail_data  out  DATA_W  data read at fail_addr

Behaviour:
- Reset, async on rst_n low: state=IDLE. mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, pass=0, fail_addr=0, fail_data=0. Pending compares are discarded.
- Reset mid-test aborts immediately. RAM contents are unspecified afterwards.
- States: IDLE -> W0 -> R0 -> R0_DRAIN -> W1 -> R1 -> R1_DRAIN -> DONE -> IDLE.
- IDLE: mem_we=0. When start=1 at an edge, go to W0, clear pass/fail_addr/fail_data, and set addr counter to 0.
- W0: mem_we=1, mem_wdata=PATTERN. Addresses run ascending 0..DEPTH-1, one per cycle (DEPTH cycles).
- R0: mem_we=0. Addresses run ascending 0..DEPTH-1, one per cycle.
  - Each issued read registers (cmp_valid, cmp_addr, cmp_exp=PATTERN).
  - The compare happens in the next cycle against mem_rdata.
- R0_DRAIN: one cycle, no new read; completes the compare of the last address.
- W1: writes ~PATTERN, addresses descending DEPTH-1..0.
- R1: reads descending DEPTH-1..0, expects ~PATTERN.
- R1_DRAIN: same as R0_DRAIN.
- DONE: one cycle. done=1, busy=0, then return to IDLE.
- Mismatch (cmp_valid && mem_rdata != cmp_exp): latch fail_addr=cmp_addr and fail_data=mem_rdata, go to DONE next cycle with pass=0.
  - Reads issued in the same cycle are dropped.
  - Only the first mismatch is recorded.
- Pass: if no mismatch by the end of R1_DRAIN, pass=1 in DONE.
- Latency, fault-free:
  - Start accepted at edge E0.
  - busy is high for 4*DEPTH+2 cycles (34 at default).
  - done is high in the cycle after edge E0+4*DEPTH+2.
- start while busy or in DONE: ignored, no queueing.
- Outside IDLE/DONE, mem_we equals 1 exactly in W0/W1. In IDLE/DONE, mem_addr holds its last value and mem_we=0.
- Address counter is ADDR_W bits with explicit terminal compare at DEPTH-1 (ascending) or 0 (descending). It never relies on natural wrap.

Decomposition:
- Shared package ram_bist_pkg holds:
  - the state enum (IDLE, W0, R0, R0_DRAIN, W1, R1, R1_DRAIN, DONE);
  - default PATTERN;
  - DEPTH/ADDR_W/DATA_W constants shared with the RAM.
- One sub-module, ram_bist_cmp: the 1-cycle read-compare pipeline stage. Inputs: issue, addr, exp, rdata. Outputs: mismatch, fail_addr, fail_data. It has its own cmp_valid register.
- FSM and address sequencer stay in the top module.

Test Plan:
- Fault-free RAM, start pulse -> busy high 34 cycles. Writes: 8 x 1010 ascending, then 8 x 0101 descending. done pulses once, pass=1, fail_addr=0.
- RAM model with bit0 stuck-at-1 at address 5 -> phase R0 reads 1011 at addr 5. done 1 cycle later, pass=0, fail_addr=5, fail_data=1011. No W1 writes issued.
- Stuck-at-0 on bit0 at address 2 (fails only ~PATTERN) -> R0 passes. R1 fails with fail_addr=2, fail_data=0100, pass=0.
- start asserted again during busy and in the DONE cycle -> ignored. Exactly one done pulse; a fresh start afterward reruns the test and clears pass/fail fields.
- rst_n low mid-W1 (addr 4) -> all outputs 0 asynchronously (before next edge). After release, a start yields a full 34-cycle busy window and pass=1.
- Last-address check: corrupt data at addr 7 in R0 and at addr 0 in R1 (separate runs) -> mismatch caught in the drain cycle. fail_addr=7 and 0 respectively.
